// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
//
// Forwarding and load-use hazard unit for an in-order pipeline. A short tag
// pipeline records, for every in-flight stage after ID, whether the
// instruction is real, which register it writes and whether it is a load.
// The ID-stage source registers are matched against these tags to select a
// bypass source. When the youngest producer is a load whose data is not yet
// available, ID is stalled.
//
// Parameters
//   ADDR_W    register address width
//   DEPTH     tracked stages after ID (1 = EX ... DEPTH = WB)
//   LOAD_LAT  first stage index at which load data can be forwarded (1..DEPTH)
//   SEL_W     forward-select width, wide enough to hold DEPTH
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   id_valid                      ID instruction is real (not a bubble)
//   id_rs, id_rt                  ID source register addresses
//   id_rd                         ID destination register address
//   id_regWrite, id_memRead       ID instruction writes a register / is a load
//   flush                         squash ID and all tracked stages
//   frwrdA, frwrdB                0 = register file, k = forward from stage k
//   stall                         load-use hazard, hold PC and IF/ID
//   stall_cnt                     saturating count of stall cycles
// -----------------------------------------------------------------------------
module fwd_scoreboard #(
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 2,
   parameter int SEL_W    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic [ADDR_W-1:0] id_rd,
   input  logic              id_regWrite,
   input  logic              id_memRead,
   input  logic              flush,
   output logic [SEL_W-1:0]  frwrdA,
   output logic [SEL_W-1:0]  frwrdB,
   output logic              stall,
   output logic [15:0]       stall_cnt
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] rd;
      logic              reg_write;
      logic              mem_read;
   } tag_t;

   tag_t tags [1:DEPTH];

   logic load_use_a;
   logic load_use_b;

   // A stage can supply a value for source s only if it really writes s;
   // register 0 is hard-wired, so it is never a producer.
   function automatic logic produces(input tag_t t, input logic [ADDR_W-1:0] s);
      return t.valid && t.reg_write && (t.rd != '0) && (t.rd == s);
   endfunction

   // ---------------------------------------------------------------------------
   // Tag pipeline
   // ---------------------------------------------------------------------------
   // NOTE: only the valid bits are reset; rd/reg_write/mem_read are ignored
   // whenever valid is 0, so clearing them would add reset fan-out for nothing.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int k = 1; k <= DEPTH; k++) begin
            tags[k].valid <= 1'b0;
         end
      end else begin
         // A stalled ID instruction stays in ID, so a bubble enters stage 1.
         tags[1].valid     <= id_valid && !stall;
         tags[1].rd        <= id_rd;
         tags[1].reg_write <= id_regWrite;
         tags[1].mem_read  <= id_memRead;
         for (int k = 2; k <= DEPTH; k++) begin
            tags[k] <= tags[k-1];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Forward selection and load-use detection
   // ---------------------------------------------------------------------------
   // Scanning from the oldest stage to the youngest lets the last hit win,
   // which is exactly the youngest producer without needing an early exit.
   // NOTE: every output of this block gets a default first, so no path
   // through the loop can leave a value held (no latch).
   always_comb begin
      frwrdA     = '0;
      frwrdB     = '0;
      load_use_a = 1'b0;
      load_use_b = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (produces(tags[k], id_rs)) begin
            frwrdA     = SEL_W'(k);
            load_use_a = tags[k].mem_read && (k < LOAD_LAT);
         end
         if (produces(tags[k], id_rt)) begin
            frwrdB     = SEL_W'(k);
            load_use_b = tags[k].mem_read && (k < LOAD_LAT);
         end
      end
      // Nothing in ID survives a flush, so there is nothing to hold back.
      stall = id_valid && !flush && (load_use_a || load_use_b);
   end

   // ---------------------------------------------------------------------------
   // Stall statistics
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fwd_scoreboard
//
// Drives two instances (default parameters, and DEPTH=5 / LOAD_LAT=3) with the
// same ID stream. A reference model keeps, per instance, a queue of the
// instructions issued over the last DEPTH cycles (index 0 = most recent) and
// derives the forward selects, stall and stall count from that history.
// Directed scenarios cover the worked examples; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_fwd_scoreboard;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [4:0] id_rd;
   logic       id_regWrite;
   logic       id_memRead;
   logic       flush;

   logic [1:0]  fa0, fb0;
   logic        st0;
   logic [15:0] sc0;
   logic [2:0]  fa1, fb1;
   logic        st1;
   logic [15:0] sc1;

   fwd_scoreboard d0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
      .flush(flush), .frwrdA(fa0), .frwrdB(fb0), .stall(st0), .stall_cnt(sc0)
   );

   fwd_scoreboard #(.ADDR_W(5), .DEPTH(5), .LOAD_LAT(3), .SEL_W(3)) d1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
      .flush(flush), .frwrdA(fa1), .frwrdB(fb1), .stall(st1), .stall_cnt(sc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: history of issued instructions per instance
   // ---------------------------------------------------------------------------
   typedef struct {
      bit valid;
      int rd;
      bit rw;
      bit mr;
   } ent_t;

   ent_t hist [2][$];
   int   dep  [2] = '{3, 5};
   int   lat  [2] = '{2, 3};
   int   cnt  [2];

   // Outputs sampled in the most recent cycle, for directed checks.
   logic [31:0] got_a [2];
   logic [31:0] got_b [2];
   logic [31:0] got_s [2];
   logic [31:0] got_c [2];

   function automatic int youngest(input int inst, input int s);
      for (int i = 0; i < hist[inst].size(); i++) begin
         if (hist[inst][i].valid && hist[inst][i].rw &&
             hist[inst][i].rd != 0 && hist[inst][i].rd == s)
            return i + 1;
      end
      return 0;
   endfunction

   function automatic bit load_use(input int inst, input int s);
      int age;
      age = youngest(inst, s);
      return (age != 0) && hist[inst][age-1].mr && (age < lat[inst]);
   endfunction

   task automatic clear_model(input int inst);
      hist[inst].delete();
      repeat (dep[inst]) hist[inst].push_back('{valid: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0});
   endtask

   // One clock cycle: drive ID, check combinational outputs, advance model.
   task automatic cycle(input bit r, input bit fl, input bit v, input int rs,
                        input int rt, input int rd, input bit rw, input bit mr);
      bit es [2];
      @(negedge clk);
      rst         = r;
      flush       = fl;
      id_valid    = v;
      id_rs       = 5'(rs);
      id_rt       = 5'(rt);
      id_rd       = 5'(rd);
      id_regWrite = rw;
      id_memRead  = mr;
      #1;
      got_a[0] = 32'(fa0); got_b[0] = 32'(fb0); got_s[0] = 32'(st0); got_c[0] = 32'(sc0);
      got_a[1] = 32'(fa1); got_b[1] = 32'(fb1); got_s[1] = 32'(st1); got_c[1] = 32'(sc1);
      for (int i = 0; i < 2; i++) begin
         es[i] = v && !fl && (load_use(i, rs) || load_use(i, rt));
         check($sformatf("d%0d.frwrdA", i),    got_a[i], youngest(i, rs));
         check($sformatf("d%0d.frwrdB", i),    got_b[i], youngest(i, rt));
         check($sformatf("d%0d.stall", i),     got_s[i], int'(es[i]));
         check($sformatf("d%0d.stall_cnt", i), got_c[i], cnt[i]);
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (r) begin
            cnt[i] = 0;
            clear_model(i);
         end else begin
            if (es[i] && cnt[i] < 65535) cnt[i]++;
            if (fl) begin
               clear_model(i);
            end else begin
               hist[i].push_front('{valid: v && !es[i], rd: rd, rw: rw, mr: mr});
               void'(hist[i].pop_back());
            end
         end
      end
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      rst = 1'b1; flush = 1'b0; id_valid = 1'b0;
      id_rs = '0; id_rt = '0; id_rd = '0; id_regWrite = 1'b0; id_memRead = 1'b0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         cnt[i] = 0;
         clear_model(i);
      end

      // Idle after reset: nothing forwards, nothing stalls.
      cycle(1'b0, 1'b0, 1'b0, 3, 7, 0, 1'b0, 1'b0);
      check("rst_fa", got_a[0], 0);
      check("rst_fb", got_b[0], 0);
      check("rst_st", got_s[0], 0);
      check("rst_cnt", got_c[0], 0);

      // ADD r3, then two readers of r3 one cycle apart.
      do_reset();
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 3, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 3, 0, 0, 1'b0, 1'b0);
      check("add_fwd1", got_a[0], 1);
      check("add_nostall", got_s[0], 0);
      cycle(1'b0, 1'b0, 1'b1, 3, 0, 0, 1'b0, 1'b0);
      check("add_fwd2", got_a[0], 2);

      // LW r5, then a dependent reader on both sources.
      do_reset();
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 5, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 5, 5, 0, 1'b0, 1'b0);
      check("lw_stall_d0", got_s[0], 1);
      check("lw_stall1_d1", got_s[1], 1);
      cycle(1'b0, 1'b0, 1'b1, 5, 5, 0, 1'b0, 1'b0);
      check("lw_fwdB_d0", got_b[0], 2);
      check("lw_same_src_d0", got_a[0], 2);
      check("lw_release_d0", got_s[0], 0);
      check("lw_cnt_d0", got_c[0], 1);
      check("lw_stall2_d1", got_s[1], 1);
      cycle(1'b0, 1'b0, 1'b1, 5, 5, 0, 1'b0, 1'b0);
      check("lw_fwdA_d1", got_a[1], 3);
      check("lw_release_d1", got_s[1], 0);
      check("lw_cnt_d1", got_c[1], 2);

      // Two writers of r4: the youngest wins.
      do_reset();
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 4, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 4, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 4, 0, 0, 1'b0, 1'b0);
      check("youngest_wins", got_a[0], 1);

      // Older load shadowed by a younger ALU producer does not stall.
      do_reset();
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 6, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 6, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 0, 6, 0, 1'b0, 1'b0);
      check("shadow_load_st", got_s[0], 0);
      check("shadow_load_fb", got_b[0], 1);

      // Writes to r0 never forward or stall.
      do_reset();
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0);
      check("r0_fa", got_a[0], 0);
      check("r0_st", got_s[0], 0);

      // LW r7, flush with a dependent in ID, then read r7.
      do_reset();
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 7, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 7, 0, 0, 1'b0, 1'b0);
      check("flush_forces_nostall", got_s[0], 0);
      cycle(1'b0, 1'b0, 1'b1, 7, 0, 0, 1'b0, 1'b0);
      check("post_flush_st", got_s[0], 0);
      check("post_flush_fa", got_a[0], 0);

      // Reset in the middle of a load-use stall.
      do_reset();
      cycle(1'b0, 1'b0, 1'b1, 0, 0, 5, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 0, 5, 0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 0, 5, 0, 1'b0, 1'b0);
      check("midstall_rst_st", got_s[0], 0);
      check("midstall_rst_cnt", got_c[0], 0);

      // Randomized traffic over a small register set to provoke hazards.
      do_reset();
      for (int n = 0; n < 600; n++) begin
         cycle(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 99) < 85),
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 9) < 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
